// File: rtl/mem_access_unit.sv
// Memory-side stage: owns MAR/MDR and sequences synchronous RAM reads/writes with wait states.
// Requests are edge-detected CU strobes; Mem_Done lets the CU stall until the access lands.
module mem_access_unit #(
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] MAR_q,
    output logic [DATA_W-1:0] MDR_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic              Mem_Busy,
    output logic              Mem_Done,
    output logic              Mem_Err
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    localparam logic [3:0] WaitCnt = 4'(WAIT_STATES);

    state_e     state_q;
    logic [3:0] cnt_q;
    logic       read_d, write_d;
    logic       rd_req, wr_req, regs_open;

    always_comb begin
        rd_req    = Read & ~read_d;
        wr_req    = Write & ~write_d;
        regs_open = (state_q == StIdle) || (state_q == StDone);
        mem_addr  = MAR_q;
        mem_wdata = MDR_q;
        Mem_Busy  = (state_q != StIdle);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            read_d   <= 1'b0;
            write_d  <= 1'b0;
            MAR_q    <= '0;
            MDR_q    <= '0;
            mem_re   <= 1'b0;
            mem_we   <= 1'b0;
            Mem_Done <= 1'b0;
            Mem_Err  <= 1'b0;
        end else begin
            // Edge detectors track every cycle so a strobe held through an access never re-fires.
            read_d   <= Read;
            write_d  <= Write;
            mem_we   <= 1'b0;
            Mem_Done <= 1'b0;
            Mem_Err  <= 1'b0;
            if (MARin && regs_open) begin
                MAR_q <= BusMuxOut[ADDR_W-1:0];
            end
            if (MDRin && !Read && regs_open) begin
                MDR_q <= BusMuxOut;
            end
            case (state_q)
                StIdle: begin
                    if (rd_req && wr_req) begin
                        Mem_Err <= 1'b1;
                    end else if (rd_req) begin
                        state_q <= StRead;
                        cnt_q   <= WaitCnt;
                        mem_re  <= 1'b1;
                    end else if (wr_req) begin
                        state_q <= StWrite;
                        cnt_q   <= WaitCnt;
                        mem_we  <= 1'b1;
                    end
                end
                StRead: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        MDR_q    <= mem_rdata;
                        mem_re   <= 1'b0;
                        Mem_Done <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StWrite: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        Mem_Done <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: table of read/write/error transactions on a WAIT_STATES=1 instance,
// plus hand sequences for reset mid-read, held strobes (WAIT_STATES=0) and MAR hold during READ.
module tb_mem_access_unit;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] BusMuxOut;
    logic        MARin, MDRin, Read, Write;

    logic [31:0] mem_rdata, MDR_q, mem_wdata;
    logic [8:0]  MAR_q, mem_addr;
    logic        mem_re, mem_we, Mem_Busy, Mem_Done, Mem_Err;

    logic [31:0] mem_rdata0, MDR_q0, mem_wdata0;
    logic [8:0]  MAR_q0, mem_addr0;
    logic        mem_re0, mem_we0, Mem_Busy0, Mem_Done0, Mem_Err0;

    logic [31:0] ram [512];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clock = ~Clock;

    mem_access_unit #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(1)) dut (
        .Clock(Clock), .Reset(Reset), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
        .Read(Read), .Write(Write), .mem_rdata(mem_rdata), .MAR_q(MAR_q), .MDR_q(MDR_q),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .Mem_Busy(Mem_Busy), .Mem_Done(Mem_Done), .Mem_Err(Mem_Err)
    );

    mem_access_unit #(.ADDR_W(9), .DATA_W(32), .WAIT_STATES(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .BusMuxOut(BusMuxOut), .MARin(MARin), .MDRin(MDRin),
        .Read(Read), .Write(Write), .mem_rdata(mem_rdata0), .MAR_q(MAR_q0), .MDR_q(MDR_q0),
        .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_re(mem_re0), .mem_we(mem_we0),
        .Mem_Busy(Mem_Busy0), .Mem_Done(Mem_Done0), .Mem_Err(Mem_Err0)
    );

    // Synchronous RAM; address is stable from before the request, so data is ready in time.
    always @(posedge Clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata  <= ram[mem_addr];
        mem_rdata0 <= 32'h5A5A_0000 ^ {23'h0, mem_addr0};
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_access(input logic rd, input logic wr, output int re_n, output int we_n,
                              output int done_at, output int err_n, output logic [8:0] wa,
                              output logic [31:0] wd);
        re_n = 0; we_n = 0; done_at = 0; err_n = 0; wa = '0; wd = '0;
        Read = rd;
        Write = wr;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (mem_re) re_n++;
            if (mem_we) begin
                we_n++;
                wa = mem_addr;
                wd = mem_wdata;
            end
            if (Mem_Done && done_at == 0) done_at = i;
            if (Mem_Err) err_n++;
            if (i == 1) begin
                Read = 1'b0;
                Write = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [8:0]  addr;
        logic [31:0] data;
        int          exp_re;
        int          exp_we;
        int          exp_done;
        int          exp_err;
        logic [31:0] exp_mdr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int re_n, we_n, done_at, err_n, cnt_a, cnt_b;
        logic [8:0]  wa;
        logic [31:0] wd;
        logic        mar_ok;

        // rd, wr, addr, data, re cycles, we pulses, Done tick, Err pulses, MDR after
        vecs[0] = '{1'b0, 1'b1, 9'h055, 32'hDEAD_BEEF, 0, 1, 3, 0, 32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 1'b1, 9'h1F0, 32'h1234_5678, 0, 1, 3, 0, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b0, 9'h055, 32'h0,         2, 0, 3, 0, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 9'h1F0, 32'h0,         2, 0, 3, 0, 32'h1234_5678};
        vecs[4] = '{1'b1, 1'b1, 9'h010, 32'h0BAD_0BAD, 0, 0, 0, 1, 32'h0BAD_0BAD};
        vecs[5] = '{1'b1, 1'b0, 9'h010, 32'h0,         2, 0, 3, 0, 32'h0000_0000};

        for (int i = 0; i < 512; i++) ram[i] = 32'h0;
        Reset = 1'b1; BusMuxOut = '0; MARin = 0; MDRin = 0; Read = 0; Write = 0;
        tick();
        tick();
        check("reset MAR_q", {23'h0, MAR_q}, 32'h0);
        check("reset MDR_q", MDR_q, 32'h0);
        check("reset outputs", {27'h0, mem_re, mem_we, Mem_Busy, Mem_Done, Mem_Err}, 32'h0);
        Reset = 1'b0;
        tick();

        foreach (vecs[v]) begin
            MARin = 1'b1;
            BusMuxOut = {23'h0, vecs[v].addr};
            tick();
            MARin = 1'b0;
            if (vecs[v].wr) begin
                MDRin = 1'b1;
                BusMuxOut = vecs[v].data;
                tick();
                MDRin = 1'b0;
            end
            check($sformatf("v%0d mem_addr", v), {23'h0, mem_addr}, {23'h0, vecs[v].addr});
            run_access(vecs[v].rd, vecs[v].wr, re_n, we_n, done_at, err_n, wa, wd);
            check($sformatf("v%0d mem_re cycles", v), re_n, vecs[v].exp_re);
            check($sformatf("v%0d mem_we pulses", v), we_n, vecs[v].exp_we);
            check($sformatf("v%0d Mem_Done tick", v), done_at, vecs[v].exp_done);
            check($sformatf("v%0d Mem_Err pulses", v), err_n, vecs[v].exp_err);
            check($sformatf("v%0d MDR_q", v), MDR_q, vecs[v].exp_mdr);
            check($sformatf("v%0d Mem_Busy idle", v), {31'h0, Mem_Busy}, 32'h0);
            if (vecs[v].exp_we != 0) begin
                check($sformatf("v%0d we addr", v), {23'h0, wa}, {23'h0, vecs[v].addr});
                check($sformatf("v%0d we data", v), wd, vecs[v].data);
            end
        end

        // Reset one cycle into READ aborts the access.
        MARin = 1'b1; BusMuxOut = 32'h055;
        tick();
        MARin = 1'b0;
        Read = 1'b1;
        tick();
        check("pre-reset busy", {31'h0, Mem_Busy}, 32'h1);
        Reset = 1'b1;
        #1;
        check("mid-reset MDR_q", MDR_q, 32'h0);
        check("mid-reset busy/re/done", {29'h0, Mem_Busy, mem_re, Mem_Done}, 32'h0);
        tick();
        check("reset held mem_re", {31'h0, mem_re}, 32'h0);
        Reset = 1'b0;
        Read = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (Mem_Done || mem_re) cnt_a++;
        end
        check("no access after reset", cnt_a, 0);

        // Read held for 10 cycles fires one access on both instances.
        MARin = 1'b1; BusMuxOut = 32'h123;
        tick();
        MARin = 1'b0;
        Read = 1'b1;
        cnt_a = 0; cnt_b = 0; done_at = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (mem_re0) cnt_a++;
            if (Mem_Done0) cnt_b++;
            if (Mem_Done) done_at++;
        end
        Read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_re0) cnt_a++;
            if (Mem_Done0) cnt_b++;
        end
        check("held read W0 mem_re cycles", cnt_a, 1);
        check("held read W0 Mem_Done", cnt_b, 1);
        check("held read W0 MDR_q", MDR_q0, 32'h5A5A_0123);
        check("held read W1 Mem_Done", done_at, 1);

        // MARin during READ is ignored until the access completes.
        MARin = 1'b1; BusMuxOut = 32'h055;
        tick();
        MARin = 1'b0;
        Read = 1'b1;
        tick();
        Read = 1'b0;
        MARin = 1'b1;
        BusMuxOut = 32'h0AA;
        mar_ok = 1'b1;
        done_at = 0;
        for (int i = 0; i < 8 && done_at == 0; i++) begin
            if (MAR_q !== 9'h055 || mem_addr !== 9'h055) mar_ok = 1'b0;
            tick();
            if (Mem_Done) done_at = i + 1;
        end
        check("MAR held during READ", {31'h0, mar_ok}, 32'h1);
        check("MAR-hold read done", {31'h0, done_at != 0}, 32'h1);
        check("MAR-hold read MDR_q", MDR_q, 32'hDEAD_BEEF);
        tick();
        MARin = 1'b0;
        tick();
        check("MAR loads after access", {23'h0, MAR_q}, 32'h0AA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
